// File: rtl/life_next_gen.sv
// rtl/life_next_gen.sv - streaming Game of Life (B3/S23) next-generation row engine
// Optional toroidal grid: define LIFE_TORUS_WRAP_EN.
module life_next_gen #(
  parameter int WIDTH  = 24,
  parameter int ROWS   = 32,
  parameter int ROW_AW = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              row_valid_in,
  input  logic [WIDTH-1:0]  row_data_in,
  output logic              busy_out,
  output logic              out_valid_out,
  output logic [ROW_AW-1:0] out_row_out,
  output logic [WIDTH-1:0]  out_data_out,
  output logic              done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_FLUSH2,
    S_DONE
  } state_t;

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  state_t              state;
  logic [ROW_AW-1:0]   k;
  logic [WIDTH-1:0]    above;
  logic [WIDTH-1:0]    mid;
  logic [WIDTH-1:0]    row0_save;
`ifdef LIFE_TORUS_WRAP_EN
  logic [WIDTH-1:0]    row1_save;
`endif

  // ext[0] is column -1 and ext[WIDTH+1] is column WIDTH
  function automatic logic [WIDTH+1:0] pad(input logic [WIDTH-1:0] x);
`ifdef LIFE_TORUS_WRAP_EN
    return {x[0], x, x[WIDTH-1]};
`else
    return {1'b0, x, 1'b0};
`endif
  endfunction

  function automatic logic [WIDTH-1:0] next_row(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH+1:0] ea;
    logic [WIDTH+1:0] ec;
    logic [WIDTH+1:0] eb;
    logic [3:0]       n;
    logic [WIDTH-1:0] r;
    ea = pad(a);
    ec = pad(c);
    eb = pad(b);
    r  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = {3'b0, ea[i]} + {3'b0, ea[i+1]} + {3'b0, ea[i+2]}
        + {3'b0, ec[i]} + {3'b0, ec[i+2]}
        + {3'b0, eb[i]} + {3'b0, eb[i+1]} + {3'b0, eb[i+2]};
      r[i] = (n == 4'd3) | (ec[i+1] & (n == 4'd2));
    end
    return r;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_IDLE;
      k             <= '0;
      above         <= '0;
      mid           <= '0;
      row0_save     <= '0;
`ifdef LIFE_TORUS_WRAP_EN
      row1_save     <= '0;
`endif
      busy_out      <= 1'b0;
      out_valid_out <= 1'b0;
      out_row_out   <= '0;
      out_data_out  <= '0;
      done_out      <= 1'b0;
    end else begin
      out_valid_out <= 1'b0;
      done_out      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            state     <= S_LOAD;
            busy_out  <= 1'b1;
            k         <= '0;
            above     <= '0;
            mid       <= '0;
            row0_save <= '0;
`ifdef LIFE_TORUS_WRAP_EN
            row1_save <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (row_valid_in) begin
            above <= mid;
            mid   <= row_data_in;
            k     <= k + ROW_AW'(1);
            if (k == '0) row0_save <= row_data_in;
`ifdef LIFE_TORUS_WRAP_EN
            // row 0 needs row ROWS-1 above it, so it is finished in FLUSH
            if (k == ROW_AW'(1)) row1_save <= row_data_in;
            if (k >= ROW_AW'(2)) begin
`else
            if (k != '0) begin
`endif
              out_valid_out <= 1'b1;
              out_row_out   <= k - ROW_AW'(1);
              out_data_out  <= next_row(above, mid, row_data_in);
            end
            if (k == LAST_ROW) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          out_valid_out <= 1'b1;
          out_row_out   <= LAST_ROW;
`ifdef LIFE_TORUS_WRAP_EN
          out_data_out  <= next_row(above, mid, row0_save);
          state         <= S_FLUSH2;
`else
          out_data_out  <= next_row(above, mid, '0);
          state         <= S_DONE;
`endif
        end
`ifdef LIFE_TORUS_WRAP_EN
        S_FLUSH2: begin
          out_valid_out <= 1'b1;
          out_row_out   <= '0;
          out_data_out  <= next_row(mid, row0_save, row1_save);
          state         <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_out <= 1'b0;
          done_out <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_next_gen.sv
// tb/tb_life_next_gen.sv - directed self-checking bench for life_next_gen
module tb_life_next_gen;
  localparam int WIDTH  = 24;
  localparam int ROWS   = 32;
  localparam int ROW_AW = 5;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              start_in;
  logic              row_valid_in;
  logic [WIDTH-1:0]  row_data_in;
  logic              busy_out;
  logic              out_valid_out;
  logic [ROW_AW-1:0] out_row_out;
  logic [WIDTH-1:0]  out_data_out;
  logic              done_out;

  always #5 clk_in = ~clk_in;

  life_next_gen #(.WIDTH(WIDTH), .ROWS(ROWS), .ROW_AW(ROW_AW)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .start_in      (start_in),
    .row_valid_in  (row_valid_in),
    .row_data_in   (row_data_in),
    .busy_out      (busy_out),
    .out_valid_out (out_valid_out),
    .out_row_out   (out_row_out),
    .out_data_out  (out_data_out),
    .done_out      (done_out)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int strobe_cnt, done_cnt, order_err, done_cyc;
  int strobe_cyc [ROWS];
  logic [WIDTH-1:0] grid     [ROWS];
  logic [WIDTH-1:0] exp_rows [ROWS];
  logic [WIDTH-1:0] got      [ROWS];

  always @(posedge clk_in) cycle <= cycle + 1;

  function automatic int exp_row_at(input int idx);
`ifdef LIFE_TORUS_WRAP_EN
    return (idx == ROWS - 1) ? 0 : idx + 1;
`else
    return idx;
`endif
  endfunction

  always @(negedge clk_in) begin
    if (out_valid_out) begin
      if (strobe_cnt < ROWS) begin
        if (int'(out_row_out) != exp_row_at(strobe_cnt)) order_err++;
        got[out_row_out]       = out_data_out;
        strobe_cyc[strobe_cnt] = cycle;
      end
      strobe_cnt++;
    end
    if (done_out) begin
      done_cnt++;
      done_cyc = cycle;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_grid();
    for (int i = 0; i < ROWS; i++) begin
      grid[i]     = '0;
      exp_rows[i] = '0;
    end
  endtask

  task automatic clear_capture();
    strobe_cnt = 0;
    done_cnt   = 0;
    order_err  = 0;
    for (int i = 0; i < ROWS; i++) got[i] = '1;
  endtask

  // feed rows [0, last_row]; gap idle cycles between valids; disturb adds stray start/valid
  task automatic feed(input int last_row, input int gap, input bit disturb);
    clear_capture();
    @(posedge clk_in); #1;
    if (disturb) begin
      row_valid_in = 1'b1;
      row_data_in  = 24'hFFFFFF;
      @(posedge clk_in); #1;
    end
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in     = 1'b0;
    row_valid_in = 1'b0;
    for (int r = 0; r <= last_row; r++) begin
      row_valid_in = 1'b1;
      row_data_in  = grid[r];
      if (disturb && (r == 5 || r == 20)) start_in = 1'b1;
      @(posedge clk_in); #1;
      row_valid_in = 1'b0;
      start_in     = 1'b0;
      row_data_in  = WIDTH'($urandom);
      if (r == 3) check_eq("busy_in_load", 32'(busy_out), 32'd1);
      repeat (gap) begin
        @(posedge clk_in); #1;
      end
    end
  endtask

  task automatic run_gen(input string tag, input int gap, input bit disturb);
    feed(ROWS - 1, gap, disturb);
    for (int t = 0; t < 40 && done_cnt == 0; t++) @(negedge clk_in);
    repeat (3) @(negedge clk_in);
    check_eq({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, " strobes"}, 32'(strobe_cnt), 32'(ROWS));
    check_eq({tag, " order_err"}, 32'(order_err), 32'd0);
    check_eq({tag, " busy_after"}, 32'(busy_out), 32'd0);
    for (int i = 0; i < ROWS; i++)
      check_eq($sformatf("%s row%0d", tag, i), 32'(got[i]), 32'(exp_rows[i]));
    if (gap == 0 && strobe_cnt == ROWS && done_cnt == 1) begin
      check_eq({tag, " strobe_span"}, 32'(strobe_cyc[ROWS-1] - strobe_cyc[0]), 32'(ROWS - 1));
      check_eq({tag, " done_lag"}, 32'(done_cyc - strobe_cyc[ROWS-1]), 32'd1);
    end
  endtask

  task automatic set_blinker(input int top);
    clear_grid();
    grid[top] = 24'h000020; grid[top+1] = 24'h000020; grid[top+2] = 24'h000020;
    exp_rows[top+1] = 24'h000070;
  endtask

  task automatic set_block();
    clear_grid();
    grid[4] = 24'h000C00; grid[5] = 24'h000C00;
    exp_rows[4] = 24'h000C00; exp_rows[5] = 24'h000C00;
  endtask

  initial begin
    rst_n_in     = 1'b0;
    start_in     = 1'b0;
    row_valid_in = 1'b0;
    row_data_in  = '0;
    clear_capture();
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst busy", 32'(busy_out), 32'd0);
    check_eq("rst valid", 32'(out_valid_out), 32'd0);
    check_eq("rst row", 32'(out_row_out), 32'd0);
    check_eq("rst data", 32'(out_data_out), 32'd0);
    check_eq("rst done", 32'(done_out), 32'd0);
    rst_n_in = 1'b1;

    set_blinker(10);
    run_gen("blinker_b2b", 0, 1'b0);
    run_gen("blinker_gap3", 3, 1'b0);
    run_gen("blinker_disturb", 0, 1'b1);

    set_block();
    run_gen("block", 1, 1'b0);

`ifndef LIFE_TORUS_WRAP_EN
    clear_grid();
    grid[0]     = 24'h000007;
    exp_rows[0] = 24'h000002;
    exp_rows[1] = 24'h000002;
    run_gen("edge", 0, 1'b0);
`else
    clear_grid();
    grid[ROWS-1] = 24'h800000; grid[0] = 24'h800000; grid[1] = 24'h800000;
    exp_rows[0]  = 24'hC00001;
    run_gen("torus", 0, 1'b0);
`endif

    // abort mid-generation while a row strobe is on the outputs
    set_blinker(13);
    feed(15, 0, 1'b0);
    check_eq("pre_abort valid", 32'(out_valid_out), 32'd1);
    check_eq("pre_abort data", 32'(out_data_out), 32'h000070);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("abort busy", 32'(busy_out), 32'd0);
    check_eq("abort valid", 32'(out_valid_out), 32'd0);
    check_eq("abort row", 32'(out_row_out), 32'd0);
    check_eq("abort data", 32'(out_data_out), 32'd0);
    repeat (4) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check_eq("abort no_done", 32'(done_cnt), 32'd0);

    set_block();
    run_gen("after_abort", 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/life_next_gen.md
Name: life_next_gen

Overview:
- Downstream consumer of the dual-plane memory reader: takes the grid one row word at a time and computes the next Game of Life generation.
- One word is one row of WIDTH cells.
- Keeps a three-row sliding window and applies rule B3/S23.
- Emits each next-generation row with its row index, for write-back into the inactive plane.

Parameters:
WIDTH, 24, cells per row (one memory word); bit i is column i
ROWS, 32, rows per generation; must be >= 3
ROW_AW, 5, row index width; 2^ROW_AW >= ROWS

Ports:
clk_in  input  1  system clock, all logic on posedge
rst_n_in  input  1  asynchronous active-low reset
start_in  input  1  one-cycle pulse; begins a generation
row_valid_in  input  1  row_data_in valid this cycle
row_data_in  input  WIDTH  current-generation row; rows arrive strictly in order 0..ROWS-1
busy_out  output  1  high from accepted start until done_out
out_valid_out  output  1  one-cycle strobe; out_row_out/out_data_out valid
out_row_out  output  ROW_AW  row index of out_data_out
out_data_out  output  WIDTH  next-generation row
done_out  output  1  one-cycle pulse after the last output row

Behaviour:
- Reset (async, rst_n_in low):
  - state IDLE; all outputs 0; window registers (above, mid, row0_save) and row counter 0.
- States: IDLE -> LOAD -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start_in=1 moves to LOAD and sets busy_out=1.
  - Clears row counter k=0 and window registers.
  - row_valid_in is ignored in IDLE.
- LOAD, on each row_valid_in:
  - Window shifts: above<=mid, mid<=row_data_in, k<=k+1.
  - Row 0 is also copied to row0_save.
  - When the accepted row index k>=1, row k-1 is computed from (above, mid, new), with above=0 for k-1=0.
  - Result registered; out_valid_out high exactly 1 cycle after the accepting cycle.
  - Gaps between valids are allowed; the window holds.
  - Row ROWS-1 accepted -> FLUSH. start_in is ignored while busy.
- FLUSH (1 cycle):
  - Computes row ROWS-1 from (above, mid, 0).
  - Output strobe the next cycle; then DONE.
- DONE: done_out=1 for 1 cycle, busy_out=0, then IDLE. A start_in in the DONE cycle is ignored.
- Per-cell rule:
  - n = sum of the 8 neighbours, 4-bit, range 0..8.
  - next = (n==3) | (cell & n==2).
  - Columns beyond 0 and WIDTH-1 are dead (no horizontal wrap).
- Output ordering (non-wrap): rows 0..ROWS-1 in order, one strobe per row, ROWS strobes total.
- Accepted row_valid_in and a FLUSH-issued output never collide: FLUSH accepts no input.
- Reset mid-generation: everything aborts immediately with no done_out. The next start_in begins a fresh generation.

Optional Feature:
- Macro LIFE_TORUS_WRAP_EN.
- Defined:
  - Toroidal grid: column -1 = column WIDTH-1, column WIDTH = column 0.
  - Vertically, row ROWS-1 neighbours row 0.
  - Row 0 output is deferred; no strobe is issued on accepting row 1. Row 1's strobe comes on accepting row 2.
  - FLUSH takes 2 cycles:
    - first computes row ROWS-1 with below=row0_save;
    - then row 0 with above=row ROWS-1 and below=saved row 1 (an extra register).
  - Output order: 1..ROWS-1, then 0.
- Undefined: dead-boundary behaviour as above; the row-1 save register and second FLUSH cycle are absent.

Test Plan:
- Blinker: rows 10,11,12 = 0x000020, all others 0 -> row 11 out = 0x000070; rows 10,12 out = 0; 32 strobes, then done_out.
- Block still life: rows 4,5 = 0x000C00 -> identical rows 4,5 out; all others 0.
- Edge death, no wrap: row 0 = 0x000007 and row 1 = 0 -> row 0 out = 0x000002 (only the centre survives); row 1 out = 0x000002 (birth).
- Torus, LIFE_TORUS_WRAP_EN:
  - rows 31,0,1 = 0x800000 (vertical blinker at column 23) -> row 0 out = 0xC00001; rows 31,1 out = 0.
  - Row 0 strobe is last.
- Throughput: row_valid_in on 32 back-to-back cycles -> strobes on 31 consecutive cycles, then FLUSH strobe, then done_out.
  - Repeat with 3-cycle gaps -> identical data.
- Robustness:
  - start_in and stray row_valid_in during LOAD do not disturb results.
  - rst_n_in low after row 15 -> all outputs 0 at once, no done_out.
  - The next start_in then yields a correct generation.
